// File: rtl/shift_pin_sout_pkg.sv
// Shared constants and types for the shift_pin_sout parallel-in/serial-out transmitter.
// The optional parity stage is enabled by defining SHIFT_PARITY_EN.
package shift_pin_sout_pkg;

    localparam int   WIDTH_DEF = 8;
    localparam logic FILL_BIT  = 1'b0;

    // Enough room for WIDTH data bits plus an optional parity bit.
    localparam int   CNT_W     = $clog2(WIDTH_DEF + 2);

    typedef enum logic [0:0] {
        ENG_IDLE     = 1'b0,
        ENG_SHIFTING = 1'b1
    } eng_state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage : shift_pin_sout_pkg

// File: rtl/shift_hold_reg.sv
// Holding register between the TI write side and the shifter, with full flag
// and sticky overrun tracking.
module shift_hold_reg
    import shift_pin_sout_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic             take_i,
    input  logic             clr_err_i,
    input  logic [0:WIDTH-1] din_i,
    output logic [0:WIDTH-1] hold_o,
    output logic             full_o,
    output logic             overrun_o
);

    logic [0:WIDTH-1] hold_q;
    logic [0:WIDTH-1] hold_d;
    logic             full_q;
    logic             full_d;
    logic             overrun_q;
    logic             overrun_d;

    // take_i is only raised while full; a write in the same cycle refills the slot.
    always_comb begin
        hold_d    = hold_q;
        full_d    = full_q;
        overrun_d = overrun_q & ~clr_err_i;
        if (take_i) begin
            full_d = wr_i;
            if (wr_i) begin
                hold_d = din_i;
            end else begin
                hold_d = hold_q;
            end
        end else if (wr_i) begin
            if (!full_q) begin
                hold_d = din_i;
                full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            full_d = full_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q    <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    assign hold_o    = hold_q;
    assign full_o    = full_q;
    assign overrun_o = overrun_q;

endmodule : shift_hold_reg

// File: rtl/shift_pin_sout.sv
// Parallel-in, serial-out transmitter for the Pi link: double-buffered, bit 0 first.
// Define SHIFT_PARITY_EN to append an odd-parity bit after each word.
module shift_pin_sout
    import shift_pin_sout_pkg::*;
#(
    parameter int   WIDTH = WIDTH_DEF,
    parameter logic FILL  = FILL_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             le,
    input  logic             shift,
    input  logic             wr,
    input  logic [0:WIDTH-1] din,
    output logic             dout,
    output logic             busy,
    output logic             hold_full,
    output logic             underrun,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SHIFT_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [CW-1:0] N_CNT = CW'(SW);

    logic [0:WIDTH-1] hold_s;
    logic             hold_full_s;
    logic             latch_s;
    logic             shift_en_s;
    logic             take_s;
    logic [0:SW-1]    load_s;
    eng_state_e       eng_state_s;

    logic [0:SW-1]    shift_q;
    logic [0:SW-1]    shift_d;
    logic [CW-1:0]    bit_cnt_q;
    logic [CW-1:0]    bit_cnt_d;
    logic             underrun_q;
    logic             underrun_d;

    assign latch_s    = cs & le;
    assign shift_en_s = cs & shift & ~le;
    assign take_s     = latch_s & hold_full_s;

`ifdef SHIFT_PARITY_EN
    assign load_s = {hold_s, ~^hold_s};
`else
    assign load_s = hold_s;
`endif

    shift_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_i      (wr),
        .take_i    (take_s),
        .clr_err_i (clr_err),
        .din_i     (din),
        .hold_o    (hold_s),
        .full_o    (hold_full_s),
        .overrun_o (overrun)
    );

    // Latch has priority over shift; a latch from an empty holding register flushes and flags underrun.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        underrun_d = underrun_q & ~clr_err;
        if (latch_s) begin
            if (hold_full_s) begin
                shift_d   = load_s;
                bit_cnt_d = N_CNT;
            end else begin
                shift_d    = {SW{FILL}};
                bit_cnt_d  = '0;
                underrun_d = 1'b1;
            end
        end else if (shift_en_s) begin
            shift_d = {shift_q[1:SW-1], FILL};
            if (bit_cnt_q != '0) begin
                bit_cnt_d = bit_cnt_q - CW'(1);
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            shift_d = shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= {SW{FILL}};
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign eng_state_s = (bit_cnt_q != '0) ? ENG_SHIFTING : ENG_IDLE;

    assign dout      = shift_q[0];
    assign busy      = (eng_state_s == ENG_SHIFTING);
    assign hold_full = hold_full_s;
    assign underrun  = underrun_q;

endmodule : shift_pin_sout

// File: tb/tb_shift_pin_sout.sv
// Self-checking bench for shift_pin_sout: directed scenarios plus random traffic,
// compared against a queue-based model of the transmitted bit stream.
module tb_shift_pin_sout;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       le;
    logic       shift;
    logic       wr;
    logic [0:7] din;
    logic       clr_err;
    logic       dout;
    logic       busy;
    logic       hold_full;
    logic       underrun;
    logic       overrun;

    int n_tests;
    int n_fail;

    // Model: pending bits as a queue, holding slot as value plus flag.
    bit         m_q[$];
    logic [7:0] m_hold;
    bit         m_full;
    bit         m_unr;
    bit         m_ovr;

    shift_pin_sout dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .le        (le),
        .shift     (shift),
        .wr        (wr),
        .din       (din),
        .dout      (dout),
        .busy      (busy),
        .hold_full (hold_full),
        .underrun  (underrun),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit s_cs, input bit s_le, input bit s_sh, input bit s_wr,
                              input logic [7:0] s_din, input bit s_clr, input bit s_rst);
        bit latch;
        bit new_full;
        if (s_rst) begin
            m_q.delete();
            m_hold = 8'h00;
            m_full = 1'b0;
            m_unr  = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            latch    = s_cs & s_le;
            new_full = m_full;
            if (s_clr) begin
                m_unr = 1'b0;
                m_ovr = 1'b0;
            end
            if (latch) begin
                m_q.delete();
                if (m_full) begin
                    for (int i = 7; i >= 0; i--) m_q.push_back(m_hold[i]);
`ifdef SHIFT_PARITY_EN
                    m_q.push_back(~^m_hold);
`endif
                    new_full = 1'b0;
                end else begin
                    m_unr = 1'b1;
                end
            end else if (s_cs && s_sh && m_q.size() > 0) begin
                void'(m_q.pop_front());
            end
            if (s_wr) begin
                if (!m_full || latch) begin
                    m_hold   = s_din;
                    new_full = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            m_full = new_full;
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_dout;
        exp_dout = (m_q.size() > 0) ? m_q[0] : 1'b0;
        check_eq({tag, ".dout"},      32'(dout),      32'(exp_dout));
        check_eq({tag, ".busy"},      32'(busy),      32'(m_q.size() > 0));
        check_eq({tag, ".hold_full"}, 32'(hold_full), 32'(m_full));
        check_eq({tag, ".underrun"},  32'(underrun),  32'(m_unr));
        check_eq({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    endtask

    task automatic step(input string tag, input bit s_cs, input bit s_le, input bit s_sh,
                        input bit s_wr, input logic [7:0] s_din, input bit s_clr, input bit s_rst);
        @(negedge clk);
        cs      = s_cs;
        le      = s_le;
        shift   = s_sh;
        wr      = s_wr;
        din     = s_din;
        clr_err = s_clr;
        rst     = s_rst;
        @(posedge clk);
        model_step(s_cs, s_le, s_sh, s_wr, s_din, s_clr, s_rst);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] a5_bits;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; cs = 1'b0; le = 1'b0; shift = 1'b0; wr = 1'b0; din = 8'h00; clr_err = 1'b0;
        m_q.delete(); m_hold = 8'h00; m_full = 1'b0; m_unr = 1'b0; m_ovr = 1'b0;

        step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("reset_dout_fill", 32'(dout), 32'd0);
        check_eq("reset_busy",      32'(busy), 32'd0);

        // A5 word with explicitly spelled-out expected serial sequence.
        a5_bits = 8'b1010_0101;
        step("a5_wr", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        step("a5_le", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("a5_bit0", 32'(dout), 32'(a5_bits[7]));
        for (int k = 1; k <= 8; k++) begin
            step("a5_sh", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifndef SHIFT_PARITY_EN
            check_eq("a5_busy", 32'(busy), 32'(k < 8));
            if (k < 8) check_eq("a5_bit", 32'(dout), 32'(a5_bits[7-k]));
            else       check_eq("a5_fill", 32'(dout), 32'd0);
`else
            check_eq("a5_busy", 32'(busy), 32'd1);
`endif
        end
        step("a5_flush", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("a5_idle_busy", 32'(busy), 32'd0);

        // Back-to-back words with refill during shifting.
        step("b2b_wr1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        step("b2b_le1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("b2b_sh",  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("b2b_wr2", 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        check_eq("b2b_no_overrun", 32'(overrun), 32'd0);
        for (int k = 0; k < 8; k++) step("b2b_sh", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("b2b_le2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("b2b_c3_bit0", 32'(dout), 32'd1);
        for (int k = 0; k < 10; k++) step("b2b_sh", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Error flags: underrun, overrun (first value kept), clear.
        step("err_unr", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("err_unr_flag", 32'(underrun), 32'd1);
        step("err_wr1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
        step("err_wr2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
        check_eq("err_ovr_flag", 32'(overrun), 32'd1);
        step("err_clr", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("err_clr_wins", 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("kept_first_bit0", 32'(dout), 32'd1);
        // cs=0 gating, then le+shift together.
        step("gate_le", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("gate_sh", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("prio", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("prio_bit0_of_55", 32'(dout), 32'd0);

        // Reset mid-word.
        step("mid_wr", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        step("mid_le", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("mid_sh", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("mid_rst_dout", 32'(dout), 32'd0);

`ifdef SHIFT_PARITY_EN
        foreach (a5_bits[i]) a5_bits[i] = 1'b0;
        step("par_wr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        step("par_le", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step("par_sh", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("par01_bit", 32'(dout), 32'd0);
        check_eq("par01_busy", 32'(busy), 32'd1);
        step("par_wr3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        step("par_le3", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step("par_sh3", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("par03_bit", 32'(dout), 32'd1);
        step("par_last", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("par03_done", 32'(busy), 32'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            step("rand",
                 ($urandom_range(3, 0) != 0),
                 ($urandom_range(7, 0) == 0),
                 ($urandom_range(1, 0) == 1),
                 ($urandom_range(5, 0) == 0),
                 8'($urandom),
                 ($urandom_range(15, 0) == 0),
                 ($urandom_range(99, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_pin_sout
